// File: rtl/kernel_mem_sched.sv
// Config-side scheduler for one kernel_mem ring buffer: allocates ring space for
// kernel loads, replays stored segments for reads and frees them after their last pass.
module kernel_mem_sched #(
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 8,
    parameter int DESC_NB    = 4,
    parameter int REP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_op,
    input  logic [MEM_AWIDTH-1:0]     cmd_len,
    input  logic [REP_WIDTH-1:0]      cmd_rep,
    input  logic                      cmd_val,
    output logic                      cmd_rdy,
    output logic [MEM_AWIDTH-1:0]     wr_cfg_end,
    output logic                      wr_cfg_set,
    input  logic                      wr_data_val,
    input  logic                      wr_data_rdy,
    output logic [MEM_AWIDTH-1:0]     rd_cfg_start,
    output logic [MEM_AWIDTH-1:0]     rd_cfg_end,
    output logic                      rd_cfg_set,
    input  logic                      rd_data_rdy,
    output logic [$clog2(DESC_NB):0]  seg_cnt,
    output logic [MEM_AWIDTH:0]       free_cnt,
    output logic                      busy,
    output logic                      err
);

    localparam int PW = (DESC_NB > 1) ? $clog2(DESC_NB) : 1;

    typedef logic [MEM_AWIDTH-1:0]    addr_t;
    typedef logic [MEM_AWIDTH:0]      wide_t;
    typedef logic [PW-1:0]            ptr_t;
    typedef logic [$clog2(DESC_NB):0] seg_t;
    typedef logic [REP_WIDTH-1:0]     rep_t;

    localparam addr_t ONE_A     = addr_t'(1);
    localparam rep_t  ONE_R     = rep_t'(1);
    localparam seg_t  ONE_S     = seg_t'(1);
    localparam wide_t DEPTH_W   = wide_t'(MEM_DEPTH);
    localparam seg_t  DESC_FULL = seg_t'(DESC_NB);
    localparam ptr_t  PTR_LAST  = ptr_t'(DESC_NB - 1);

    typedef enum logic [2:0] {IDLE, WR_CFG, WR_BUSY, RD_CFG, RD_BUSY} state_t;

    state_t state;
    addr_t  wr_ptr;
    addr_t  wr_len;
    addr_t  wr_cnt;
    addr_t  rd_len;
    addr_t  rd_cnt;
    rep_t   rd_pass;
    ptr_t   head;
    ptr_t   tail;
    addr_t  d_start [DESC_NB];
    addr_t  d_end   [DESC_NB];
    addr_t  d_len   [DESC_NB];
    logic   cmd_fire;
    logic   wr_beat;
    logic   wr_last;

    // Compare-and-subtract keeps the wrap correct for non-power-of-two depths;
    // both operands are always below MEM_DEPTH so one subtraction suffices.
    function automatic addr_t wrap_add(addr_t base, addr_t off);
        wide_t sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= DEPTH_W)
            sum = sum - DEPTH_W;
        return sum[MEM_AWIDTH-1:0];
    endfunction

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

    assign cmd_fire = cmd_val && cmd_rdy && (state == IDLE);
    assign wr_beat  = (state == WR_BUSY) && wr_data_val && wr_data_rdy;
    assign wr_last  = wr_beat && (wr_cnt + ONE_A == wr_len);

    always_ff @(posedge clk) begin
        if (wr_last) begin
            d_start[tail] <= wr_ptr;
            d_end[tail]   <= wr_cfg_end;
            d_len[tail]   <= wr_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            wr_len       <= '0;
            wr_cnt       <= '0;
            rd_len       <= '0;
            rd_cnt       <= '0;
            rd_pass      <= '0;
            head         <= '0;
            tail         <= '0;
            cmd_rdy      <= 1'b0;
            wr_cfg_end   <= '0;
            wr_cfg_set   <= 1'b0;
            rd_cfg_start <= '0;
            rd_cfg_end   <= '0;
            rd_cfg_set   <= 1'b0;
            seg_cnt      <= '0;
            free_cnt     <= DEPTH_W;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wr_cfg_set <= 1'b0;
            rd_cfg_set <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (cmd_fire) begin
                        if (!cmd_op) begin
                            if (cmd_len == '0 || wide_t'(cmd_len) > free_cnt || seg_cnt == DESC_FULL) begin
                                err <= 1'b1;
                            end else begin
                                wr_len     <= cmd_len;
                                wr_cnt     <= '0;
                                wr_cfg_end <= wrap_add(wr_ptr, cmd_len - ONE_A);
                                wr_cfg_set <= 1'b1;
                                cmd_rdy    <= 1'b0;
                                busy       <= 1'b1;
                                state      <= WR_CFG;
                            end
                        end else if (seg_cnt == '0) begin
                            err <= 1'b1;
                        end else if (cmd_rep == '0) begin
                            head     <= ptr_inc(head);
                            seg_cnt  <= seg_cnt - ONE_S;
                            free_cnt <= free_cnt + wide_t'(d_len[head]);
                        end else begin
                            rd_cfg_start <= d_start[head];
                            rd_cfg_end   <= d_end[head];
                            rd_len       <= d_len[head];
                            rd_pass      <= cmd_rep;
                            rd_cnt       <= '0;
                            rd_cfg_set   <= 1'b1;
                            cmd_rdy      <= 1'b0;
                            busy         <= 1'b1;
                            state        <= RD_CFG;
                        end
                    end
                end
                WR_CFG: state <= WR_BUSY;
                WR_BUSY: begin
                    if (wr_last) begin
                        tail     <= ptr_inc(tail);
                        seg_cnt  <= seg_cnt + ONE_S;
                        free_cnt <= free_cnt - wide_t'(wr_len);
                        wr_ptr   <= wrap_add(wr_cfg_end, ONE_A);
                        cmd_rdy  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (wr_beat) begin
                        wr_cnt <= wr_cnt + ONE_A;
                    end
                end
                RD_CFG: state <= RD_BUSY;
                RD_BUSY: begin
                    if (rd_data_rdy) begin
                        if (rd_cnt + ONE_A == rd_len) begin
                            rd_cnt <= '0;
                            if (rd_pass == ONE_R) begin
                                head     <= ptr_inc(head);
                                seg_cnt  <= seg_cnt - ONE_S;
                                free_cnt <= free_cnt + wide_t'(rd_len);
                                cmd_rdy  <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                rd_pass <= rd_pass - ONE_R;
                            end
                        end else begin
                            rd_cnt <= rd_cnt + ONE_A;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_mem_sched.sv
// Randomized bench for kernel_mem_sched against a queue-based model of ring
// allocation, descriptor storage and read replay.
module tb_kernel_mem_sched;

    localparam int DEPTH = 8;
    localparam int DNB   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_op = 1'b0;
    logic [7:0] cmd_len = '0;
    logic [7:0] cmd_rep = '0;
    logic       cmd_val = 1'b0;
    logic       cmd_rdy;
    logic [7:0] wr_cfg_end;
    logic       wr_cfg_set;
    logic       wr_data_val = 1'b0;
    logic       wr_data_rdy = 1'b0;
    logic [7:0] rd_cfg_start;
    logic [7:0] rd_cfg_end;
    logic       rd_cfg_set;
    logic       rd_data_rdy = 1'b0;
    logic [2:0] seg_cnt;
    logic [8:0] free_cnt;
    logic       busy;
    logic       err;

    kernel_mem_sched #(
        .MEM_AWIDTH(8),
        .MEM_DEPTH (DEPTH),
        .DESC_NB   (DNB),
        .REP_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_rep     (cmd_rep),
        .cmd_val     (cmd_val),
        .cmd_rdy     (cmd_rdy),
        .wr_cfg_end  (wr_cfg_end),
        .wr_cfg_set  (wr_cfg_set),
        .wr_data_val (wr_data_val),
        .wr_data_rdy (wr_data_rdy),
        .rd_cfg_start(rd_cfg_start),
        .rd_cfg_end  (rd_cfg_end),
        .rd_cfg_set  (rd_cfg_set),
        .rd_data_rdy (rd_data_rdy),
        .seg_cnt     (seg_cnt),
        .free_cnt    (free_cnt),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {int s; int e; int l;} desc_t;
    desc_t m_q[$];
    int    m_ptr;
    int    m_free;
    int    vec_cnt = 0;
    int    err_cnt = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_free = DEPTH;
        m_q.delete();
    endtask

    task automatic do_load(input int len);
        int exp_end;
        int beats;
        int budget;
        bit rej;
        logic v;
        logic r;
        vec_cnt++; if (cmd_rdy !== 1'b1) begin err_cnt++; $display("FAIL load_cmd_rdy got %0d want 1", cmd_rdy); end
        rej = (len == 0) || (len > m_free) || (m_q.size() == DNB);
        exp_end = rej ? 0 : (m_ptr + len - 1) % DEPTH;
        cmd_op = 1'b0; cmd_len = 8'(len); cmd_val = 1'b1;
        cyc();
        cmd_val = 1'b0;
        if (rej) begin
            vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL load_rej_err len=%0d got %0d want 1", len, err); end
            vec_cnt++; if (wr_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL load_rej_set got %0d want 0", wr_cfg_set); end
            vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL load_rej_busy got %0d want 0", busy); end
            vec_cnt++; if (free_cnt !== 9'(m_free)) begin err_cnt++; $display("FAIL load_rej_free got %0d want %0d", free_cnt, m_free); end
            vec_cnt++; if (seg_cnt !== 3'(m_q.size())) begin err_cnt++; $display("FAIL load_rej_seg got %0d want %0d", seg_cnt, m_q.size()); end
            cyc();
            vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL load_err_pulse got %0d want 0", err); end
            return;
        end
        vec_cnt++; if (wr_cfg_set !== 1'b1) begin err_cnt++; $display("FAIL load_set got %0d want 1", wr_cfg_set); end
        vec_cnt++; if (wr_cfg_end !== 8'(exp_end)) begin err_cnt++; $display("FAIL load_end len=%0d got %0d want %0d", len, wr_cfg_end, exp_end); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL load_busy_start got %0d want 1", busy); end
        vec_cnt++; if (cmd_rdy !== 1'b0) begin err_cnt++; $display("FAIL load_rdy_low got %0d want 0", cmd_rdy); end
        wr_data_val = 1'b1; wr_data_rdy = 1'b1;
        cyc();
        vec_cnt++; if (wr_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL load_set_pulse got %0d want 0", wr_cfg_set); end
        beats = 0;
        budget = 0;
        while (beats < len && budget < 500) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            wr_data_val = v; wr_data_rdy = r;
            cyc();
            budget++;
            if (v && r) beats++;
            if (beats < len) begin
                vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL load_busy_mid beats=%0d got %0d want 1", beats, busy); end
            end
        end
        wr_data_val = 1'b0; wr_data_rdy = 1'b0;
        if (beats < len) begin vec_cnt++; err_cnt++; $display("FAIL load_timeout got %0d beats want %0d", beats, len); end
        m_q.push_back('{m_ptr, exp_end, len});
        m_ptr  = (exp_end + 1) % DEPTH;
        m_free = m_free - len;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL load_busy_end got %0d want 0", busy); end
        vec_cnt++; if (cmd_rdy !== 1'b1) begin err_cnt++; $display("FAIL load_rdy_end got %0d want 1", cmd_rdy); end
        vec_cnt++; if (seg_cnt !== 3'(m_q.size())) begin err_cnt++; $display("FAIL load_seg got %0d want %0d", seg_cnt, m_q.size()); end
        vec_cnt++; if (free_cnt !== 9'(m_free)) begin err_cnt++; $display("FAIL load_free got %0d want %0d", free_cnt, m_free); end
        vec_cnt++; if (wr_cfg_end !== 8'(exp_end)) begin err_cnt++; $display("FAIL load_end_hold got %0d want %0d", wr_cfg_end, exp_end); end
    endtask

    task automatic do_run(input int rep);
        desc_t d;
        int total;
        int beats;
        int budget;
        logic r;
        vec_cnt++; if (cmd_rdy !== 1'b1) begin err_cnt++; $display("FAIL run_cmd_rdy got %0d want 1", cmd_rdy); end
        cmd_op = 1'b1; cmd_rep = 8'(rep); cmd_val = 1'b1;
        cyc();
        cmd_val = 1'b0;
        if (m_q.size() == 0) begin
            vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL run_empty_err got %0d want 1", err); end
            vec_cnt++; if (rd_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL run_empty_set got %0d want 0", rd_cfg_set); end
            vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL run_empty_busy got %0d want 0", busy); end
            cyc();
            vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL run_err_pulse got %0d want 0", err); end
            return;
        end
        d = m_q[0];
        if (rep == 0) begin
            void'(m_q.pop_front());
            m_free = m_free + d.l;
            vec_cnt++; if (rd_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL run0_set got %0d want 0", rd_cfg_set); end
            vec_cnt++; if (busy !== 1'b0 || err !== 1'b0) begin err_cnt++; $display("FAIL run0_busy_err got %0d%0d want 00", busy, err); end
            vec_cnt++; if (seg_cnt !== 3'(m_q.size())) begin err_cnt++; $display("FAIL run0_seg got %0d want %0d", seg_cnt, m_q.size()); end
            vec_cnt++; if (free_cnt !== 9'(m_free)) begin err_cnt++; $display("FAIL run0_free got %0d want %0d", free_cnt, m_free); end
            return;
        end
        vec_cnt++; if (rd_cfg_set !== 1'b1) begin err_cnt++; $display("FAIL run_set got %0d want 1", rd_cfg_set); end
        vec_cnt++; if (rd_cfg_start !== 8'(d.s)) begin err_cnt++; $display("FAIL run_start got %0d want %0d", rd_cfg_start, d.s); end
        vec_cnt++; if (rd_cfg_end !== 8'(d.e)) begin err_cnt++; $display("FAIL run_end got %0d want %0d", rd_cfg_end, d.e); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL run_busy_start got %0d want 1", busy); end
        cyc();
        vec_cnt++; if (rd_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL run_set_pulse got %0d want 0", rd_cfg_set); end
        total = rep * d.l;
        beats = 0;
        budget = 0;
        while (beats < total && budget < 4000) begin
            r = ($urandom_range(0, 3) != 0);
            rd_data_rdy = r;
            cyc();
            budget++;
            if (r) beats++;
            if (beats < total) begin
                vec_cnt++; if (busy !== 1'b1 || rd_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL run_busy_mid beats=%0d got busy=%0d set=%0d want 1 0", beats, busy, rd_cfg_set); end
            end
        end
        rd_data_rdy = 1'b0;
        if (beats < total) begin vec_cnt++; err_cnt++; $display("FAIL run_timeout got %0d beats want %0d", beats, total); end
        void'(m_q.pop_front());
        m_free = m_free + d.l;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL run_busy_end got %0d want 0", busy); end
        vec_cnt++; if (seg_cnt !== 3'(m_q.size())) begin err_cnt++; $display("FAIL run_seg got %0d want %0d", seg_cnt, m_q.size()); end
        vec_cnt++; if (free_cnt !== 9'(m_free)) begin err_cnt++; $display("FAIL run_free got %0d want %0d", free_cnt, m_free); end
        vec_cnt++; if (rd_cfg_start !== 8'(d.s) || rd_cfg_end !== 8'(d.e)) begin err_cnt++; $display("FAIL run_cfg_hold got %0d..%0d want %0d..%0d", rd_cfg_start, rd_cfg_end, d.s, d.e); end
    endtask

    task automatic check_reset_outputs(input bit rdy_exp);
        vec_cnt++; if (cmd_rdy !== rdy_exp) begin err_cnt++; $display("FAIL rst_cmd_rdy got %0d want %0d", cmd_rdy, rdy_exp); end
        vec_cnt++; if (wr_cfg_end !== 8'd0 || wr_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL rst_wr_cfg got %0d/%0d want 0/0", wr_cfg_end, wr_cfg_set); end
        vec_cnt++; if (rd_cfg_start !== 8'd0 || rd_cfg_end !== 8'd0 || rd_cfg_set !== 1'b0) begin err_cnt++; $display("FAIL rst_rd_cfg got %0d/%0d/%0d want 0/0/0", rd_cfg_start, rd_cfg_end, rd_cfg_set); end
        vec_cnt++; if (seg_cnt !== 3'd0) begin err_cnt++; $display("FAIL rst_seg got %0d want 0", seg_cnt); end
        vec_cnt++; if (free_cnt !== 9'(DEPTH)) begin err_cnt++; $display("FAIL rst_free got %0d want %0d", free_cnt, DEPTH); end
        vec_cnt++; if (busy !== 1'b0 || err !== 1'b0) begin err_cnt++; $display("FAIL rst_busy_err got %0d%0d want 00", busy, err); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) cyc();
        check_reset_outputs(1'b0);
        rst = 1'b1;
        cyc();
        vec_cnt++; if (cmd_rdy !== 1'b1) begin err_cnt++; $display("FAIL rst_release_rdy got %0d want 1", cmd_rdy); end
    endtask

    task automatic test_load_basic();
        do_load(5);
    endtask

    task automatic test_load_reject();
        do_load(4);
        do_load(0);
        do_load(3);
    endtask

    task automatic test_run();
        do_run(2);
    endtask

    task automatic test_wrap();
        do_load(4);
        do_run(1);
    endtask

    task automatic test_empty_and_discard();
        do_run(0);
        do_run(1);
    endtask

    task automatic test_seg_full();
        do_load(1);
        do_load(2);
        do_load(1);
        do_load(1);
        do_load(1);
        do_run(0);
        do_run(1);
        do_run(0);
        do_run(2);
    endtask

    task automatic test_reset_mid();
        cmd_op = 1'b0; cmd_len = 8'd5; cmd_val = 1'b1;
        cyc();
        cmd_val = 1'b0;
        cyc();
        wr_data_val = 1'b1; wr_data_rdy = 1'b1;
        repeat (2) cyc();
        wr_data_val = 1'b0; wr_data_rdy = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs(1'b0);
        model_reset();
        cyc();
        rst = 1'b1;
        cyc();
        do_load(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_load(int'($urandom_range(0, DEPTH + 1)));
            else
                do_run(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_basic();
        test_load_reject();
        test_run();
        test_wrap();
        test_empty_and_discard();
        test_seg_full();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
